// File: rtl/fir_tap_sequencer.sv
// Sequencer and tap storage feeding an 18x36 FIR MAC: one output per accepted sample.
// Holds the circular sample delay line and the coefficient bank, and captures the drained MAC result.
module fir_tap_sequencer #(
  parameter int NTAPS  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [35:0]       din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [17:0]       coef_wdata,
  output logic [17:0]       mac_a,
  output logic [35:0]       mac_b,
  output logic              mac_clr,
  input  logic [67:0]       mac_out,
  output logic [67:0]       dout,
  output logic              dout_valid,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for a sample; coefficient writes allowed
  // CLEAR | one cycle of mac_clr before the tap stream
  // RUN   | one coefficient/sample pair per cycle, tap k = 0..NTAPS-1
  // DRAIN | three empty cycles while the MAC pipeline settles
  // OUT   | dout_valid pulse for the captured result
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam int                CW    = ADDR_W + 1;
  localparam logic [CW-1:0]     NT_F  = CW'(NTAPS);
  localparam logic [ADDR_W-1:0] NT_A  = ADDR_W'(NTAPS);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NTAPS - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] newest;
  logic [ADDR_W-1:0] k;
  logic [CW-1:0]     fill;
  logic [1:0]        drain_cnt;

  logic [35:0] delay_mem [NTAPS];
  logic [17:0] coef_mem  [NTAPS];

  logic              accept;
  logic [ADDR_W-1:0] tap_sel;
  logic [ADDR_W-1:0] rd_idx;
  logic              tap_live;

  assign accept = reset && din_valid && din_ready && (state == S_IDLE);

  // Tap to present next cycle; the index wrap is done modulo NTAPS, not 2**ADDR_W.
  always_comb begin
    tap_sel  = (state == S_CLEAR) ? '0 : k + ADDR_W'(1);
    rd_idx   = newest - tap_sel + ((newest < tap_sel) ? NT_A : '0);
    tap_live = ({1'b0, tap_sel} < fill);
  end

  always_ff @(posedge clock) begin
    if (accept)
      delay_mem[wr_ptr] <= din;
    if (reset && coef_we && (state == S_IDLE) && ({1'b0, coef_addr} < NT_F))
      coef_mem[coef_addr] <= coef_wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      newest     <= '0;
      k          <= '0;
      fill       <= '0;
      drain_cnt  <= '0;
      mac_a      <= '0;
      mac_b      <= '0;
      mac_clr    <= 1'b1;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      din_ready  <= 1'b0;
    end else begin
      mac_a      <= '0;
      mac_b      <= '0;
      mac_clr    <= 1'b0;
      dout_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            newest    <= wr_ptr;
            wr_ptr    <= (wr_ptr == LAST) ? '0 : wr_ptr + ADDR_W'(1);
            if (fill != NT_F)
              fill <= fill + CW'(1);
            state     <= S_CLEAR;
            mac_clr   <= 1'b1;
            din_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            din_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        S_CLEAR: begin
          state <= S_RUN;
          k     <= '0;
          mac_a <= coef_mem[tap_sel];
          mac_b <= tap_live ? delay_mem[rd_idx] : '0;
        end
        S_RUN: begin
          if (k == LAST) begin
            state     <= S_DRAIN;
            drain_cnt <= 2'd2;
          end else begin
            k     <= k + ADDR_W'(1);
            mac_a <= coef_mem[tap_sel];
            mac_b <= tap_live ? delay_mem[rd_idx] : '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'd0) begin
            dout       <= mac_out;
            dout_valid <= 1'b1;
            state      <= S_OUT;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        S_OUT: begin
          state     <= S_IDLE;
          din_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          din_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: three instances (4, 3 and 64 taps) each driving a 3-stage MAC model.
// Expected outputs come from a direct convolution of the sample history and are checked via a scoreboard.
module tb_fir_tap_sequencer;

  localparam int NT [3] = '{4, 3, 64};

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [35:0] din        [3];
  logic        din_valid  [3];
  logic        din_ready  [3];
  logic        coef_we    [3];
  logic [5:0]  coef_addr  [3];
  logic [17:0] coef_wdata [3];
  logic [17:0] mac_a      [3];
  logic [35:0] mac_b      [3];
  logic        mac_clr    [3];
  logic [67:0] mac_out    [3];
  logic [67:0] dout       [3];
  logic        dout_valid [3];
  logic        busy       [3];

  logic [67:0] exp_q [3][$];
  int          exp_c [3][$];
  longint      hist  [3][$];
  longint      cf    [3][64];
  int          last_acc [3];

  fir_tap_sequencer #(.NTAPS(4), .ADDR_W(2)) u4 (
    .clock(clock), .reset(reset), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
    .coef_we(coef_we[0]), .coef_addr(coef_addr[0][1:0]), .coef_wdata(coef_wdata[0]),
    .mac_a(mac_a[0]), .mac_b(mac_b[0]), .mac_clr(mac_clr[0]), .mac_out(mac_out[0]),
    .dout(dout[0]), .dout_valid(dout_valid[0]), .busy(busy[0]));

  fir_tap_sequencer #(.NTAPS(3), .ADDR_W(2)) u3 (
    .clock(clock), .reset(reset), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
    .coef_we(coef_we[1]), .coef_addr(coef_addr[1][1:0]), .coef_wdata(coef_wdata[1]),
    .mac_a(mac_a[1]), .mac_b(mac_b[1]), .mac_clr(mac_clr[1]), .mac_out(mac_out[1]),
    .dout(dout[1]), .dout_valid(dout_valid[1]), .busy(busy[1]));

  fir_tap_sequencer #(.NTAPS(64), .ADDR_W(6)) u64 (
    .clock(clock), .reset(reset), .din(din[2]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
    .coef_we(coef_we[2]), .coef_addr(coef_addr[2]), .coef_wdata(coef_wdata[2]),
    .mac_a(mac_a[2]), .mac_b(mac_b[2]), .mac_clr(mac_clr[2]), .mac_out(mac_out[2]),
    .dout(dout[2]), .dout_valid(dout_valid[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // MAC model (input reg, product reg, accumulator) and output monitor per instance.
  for (genvar g = 0; g < 3; g++) begin : env_g
    logic signed [17:0] a_r = '0;
    logic signed [35:0] b_r = '0;
    logic signed [67:0] p_r = '0;
    logic signed [67:0] acc = '0;
    always @(posedge clock) begin
      a_r <= mac_a[g];
      b_r <= mac_b[g];
      p_r <= a_r * b_r;
      acc <= mac_clr[g] ? '0 : acc + p_r;
    end
    assign mac_out[g] = acc;

    always @(negedge clock) begin
      if (dout_valid[g]) begin
        if (exp_q[g].size() == 0) begin
          check($sformatf("spurious_dout_valid_u%0d", g), 68'(dout_valid[g]), 68'd0);
        end else begin
          check($sformatf("dout_u%0d", g), dout[g], exp_q[g].pop_front());
          check($sformatf("latency_u%0d", g), 68'(cyc), 68'(exp_c[g].pop_front()));
        end
      end
    end
  end

  task automatic send(input int i, input longint x, input bit chk_gap);
    logic signed [67:0] e;
    longint s;
    @(negedge clock);
    din[i] = x[35:0];
    din_valid[i] = 1'b1;
    for (int t = 0; t < 300 && !din_ready[i]; t++) @(negedge clock);
    if (!din_ready[i]) begin
      check($sformatf("accept_timeout_u%0d", i), 68'(din_ready[i]), 68'd1);
      din_valid[i] = 1'b0;
      return;
    end
    if (chk_gap) check($sformatf("accept_gap_u%0d", i), 68'(cyc - last_acc[i]), 68'(NT[i] + 6));
    last_acc[i] = cyc;
    hist[i].push_front(x);
    if (hist[i].size() > NT[i]) void'(hist[i].pop_back());
    s = 0;
    for (int k = 0; k < hist[i].size(); k++) s += cf[i][k] * hist[i][k];
    e = s;
    exp_q[i].push_back(e);
    exp_c[i].push_back(cyc + NT[i] + 5);
    @(posedge clock);
  endtask

  task automatic release_valid(input int i);
    @(negedge clock);
    din_valid[i] = 1'b0;
  endtask

  task automatic wcoef(input int i, input int addr, input int val);
    @(negedge clock);
    coef_we[i] = 1'b1;
    coef_addr[i] = addr[5:0];
    coef_wdata[i] = val[17:0];
    @(negedge clock);
    coef_we[i] = 1'b0;
    cf[i][addr] = val;
  endtask

  task automatic wait_done(input int i);
    for (int t = 0; t < 3000; t++) begin
      if (exp_q[i].size() == 0 && !busy[i] && din_ready[i]) break;
      @(negedge clock);
    end
    check($sformatf("drain_done_u%0d", i), 68'(exp_q[i].size()), 68'd0);
  endtask

  task automatic clear_models();
    for (int i = 0; i < 3; i++) begin
      hist[i].delete();
      exp_q[i].delete();
      exp_c[i].delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    clear_models();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [67:0] big;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; din_valid[i] = 1'b0; coef_we[i] = 1'b0;
      coef_addr[i] = '0; coef_wdata[i] = '0; last_acc[i] = 0;
      for (int k = 0; k < 64; k++) cf[i][k] = 0;
    end

    repeat (2) @(negedge clock);
    check("rst_mac_a", 68'(mac_a[0]), 68'd0);
    check("rst_mac_b", 68'(mac_b[0]), 68'd0);
    check("rst_mac_clr", 68'(mac_clr[0]), 68'd1);
    check("rst_dout", dout[0], 68'd0);
    check("rst_dout_valid", 68'(dout_valid[0]), 68'd0);
    check("rst_busy", 68'(busy[0]), 68'd0);
    check("rst_din_ready", 68'(din_ready[0]), 68'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_din_ready", 68'(din_ready[0]), 68'd1);
    check("idle_mac_clr", 68'(mac_clr[0]), 68'd0);

    // Impulse response 1,2,3,4,0
    for (int k = 0; k < 4; k++) wcoef(0, k, k + 1);
    send(0, 1, 0);
    for (int n = 0; n < 4; n++) send(0, 0, 0);
    release_valid(0);
    wait_done(0);

    // Stale delay-line contents must not leak after reset empties the history
    for (int k = 0; k < 4; k++) wcoef(0, k, 1);
    for (int n = 0; n < 4; n++) send(0, 64'h7FFFFFFFF, 0);
    release_valid(0);
    wait_done(0);
    do_reset();
    send(0, 5, 0);
    send(0, 7, 0);
    send(0, -3, 0);
    release_valid(0);
    wait_done(0);
    check("fill_last_dout", dout[0], 68'd9);

    // Pointer wrap with three taps: x[n], then x[n-2]
    wcoef(1, 0, 1); wcoef(1, 1, 0); wcoef(1, 2, 0);
    for (int n = 1; n <= 5; n++) send(1, n, 0);
    release_valid(1);
    wait_done(1);
    wcoef(1, 0, 0); wcoef(1, 2, 1);
    for (int n = 6; n <= 10; n++) send(1, n, 0);
    release_valid(1);
    wait_done(1);
    check("wrap_last_dout", dout[1], 68'd8);

    // Full-scale negative coefficients and samples
    for (int k = 0; k < 64; k++) wcoef(2, k, -131072);
    for (int n = 0; n < 64; n++) send(2, -(64'sd1 <<< 35), 0);
    release_valid(2);
    wait_done(2);
    big = 68'd1 << 58;
    check("extreme_last_dout", dout[2], big);

    // din_valid held high: accepts every NTAPS+6 cycles; a coef write during RUN is dropped
    send(0, 1, 0);
    repeat (3) @(negedge clock);
    coef_we[0] = 1'b1; coef_addr[0] = 6'd0; coef_wdata[0] = 18'd100;
    @(negedge clock);
    coef_we[0] = 1'b0;
    send(0, 2, 1);
    send(0, 3, 1);
    release_valid(0);
    wait_done(0);
    check("gating_last_dout", dout[0], 68'd3);

    // Reset at RUN tap 2 aborts the sample and discards history
    send(0, 9, 0);
    release_valid(0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("abort_mac_clr", 68'(mac_clr[0]), 68'd1);
    check("abort_dout_valid", 68'(dout_valid[0]), 68'd0);
    check("abort_busy", 68'(busy[0]), 68'd0);
    reset = 1'b1;
    clear_models();
    repeat (20) @(negedge clock);
    send(0, 3, 0);
    release_valid(0);
    wait_done(0);
    check("abort_next_dout", dout[0], 68'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Control and storage stage directly upstream of the 18x36 FIR multiply-accumulate unit. It accepts one 36-bit signed input sample per handshake and keeps the last NTAPS samples in a circular delay line. It holds NTAPS 18-bit signed coefficients and streams one coefficient/sample pair per cycle into the MAC. It then clears and drains the MAC pipeline and captures the 68-bit accumulated result as one filter output per input sample.

## Interface
- NTAPS, 64, number of filter taps; legal range 2..2**ADDR_W, need not be a power of two.
- ADDR_W, 6, width of tap/coefficient addresses.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- din  in  36  signed input sample.
- din_valid  in  1  sample offered.
- din_ready  out  1  block accepts a sample this cycle. It is high only in IDLE.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  ADDR_W  coefficient index; tap k multiplies x[n-k].
- coef_wdata  in  18  signed coefficient.
- mac_a  out  18  coefficient to MAC A port.
- mac_b  out  36  sample to MAC B port.
- mac_clr  out  1  active-high synchronous clear to MAC reset port.
- mac_out  in  68  MAC accumulator output.
- dout  out  68  signed filter output.
- dout_valid  out  1  one-cycle pulse; dout holds a new result.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, CLEAR, RUN, DRAIN, OUT.
- Reset (reset=0) sets the following:
  - state IDLE; wr_ptr 0; fill count 0.
  - mac_a 0, mac_b 0, mac_clr 1.
  - dout 0, dout_valid 0, busy 0, din_ready 0 during reset.
  - Delay-line and coefficient storage are not reset.
- IDLE: din_ready=1, mac_clr=0, mac_a=mac_b=0.
  - On din_valid&&din_ready: write din to delay line at wr_ptr, latch that pointer as the newest index, advance wr_ptr (NTAPS-1 wraps to 0), increment fill (saturates at NTAPS). Next state CLEAR.
- CLEAR: one cycle; mac_clr=1, mac_a=mac_b=0. Next state RUN with tap k=0.
- RUN: NTAPS cycles, k=0..NTAPS-1.
  - mac_a=coef[k].
  - mac_b=delay[(newest-k) mod NTAPS] if k<fill, else 0. Samples never received contribute zero, so stale RAM contents never leak.
  - After k=NTAPS-1, next state DRAIN.
- DRAIN: 3 cycles, mac_a=mac_b=0, covering the MAC's 3-stage input/product/accumulate latency.
  - On the clock edge ending the third DRAIN cycle, dout<=mac_out. Next state OUT.
- OUT: one cycle; dout_valid=1, busy=1. Next state IDLE. dout holds its value until the next capture.
- Coefficient writes take effect only in IDLE (coef[coef_addr]<=coef_wdata at the edge). Writes in any other state are dropped. Writes with coef_addr>=NTAPS are dropped.
- A write and a sample accept in the same IDLE cycle are both performed. The new coefficient applies to this sample's RUN.
- Width rule: |coef·sample| < 2**53, and the sum of NTAPS terms is < 2**59. The 68-bit result never overflows. dout is mac_out unmodified.
- Reset low in any state aborts the computation. No dout_valid pulse is produced for the aborted sample. mac_clr=1 is asserted, and the state returns to IDLE with fill=0.

## Timing
- mac_a, mac_b, mac_clr, dout, dout_valid, din_ready and busy are all registered outputs.
- Let accept edge be E0. Then:
  - CLEAR runs in cycle 1.
  - RUN runs in cycles 2..NTAPS+1.
  - DRAIN runs in cycles NTAPS+2..NTAPS+4.
  - dout_valid is high in cycle NTAPS+5.
  - din_ready is high again in cycle NTAPS+6.
- Throughput: one sample per NTAPS+6 cycles. With din_valid held high, accepts occur exactly every NTAPS+6 cycles.
- The MAC's last product (tap NTAPS-1 presented in cycle NTAPS+1) is in mac_out during cycle NTAPS+4, which is the cycle captured.

## Test plan
- Impulse, NTAPS=4, coef={1,2,3,4}, samples 1,0,0,0,0 → dout 1,2,3,4,0. Each dout_valid arrives exactly 9 cycles after its accept edge.
- Fill boundary, NTAPS=4, coef all 1, with uninitialised delay RAM forced to 0x7FFFFFFFF, samples 5,7,-3 → dout 5,12,9. Stale RAM contents are not used.
- Wrap-around, NTAPS=3, coef={1,0,0} then {0,0,1}, samples 1..10 → each output equals x[n] for the first set, then x[n-2] for the second, across several pointer wraps.
- Extremes, NTAPS=64, every coef=-131072, 64 samples of -2**35 → last dout = +2**58 exactly, with no sign error.
- Back-pressure and coef gating: din_valid held high → accepts spaced 10 cycles apart (NTAPS=4). A coef_we pulse during RUN is ignored and the output is unchanged.
- Reset mid-RUN at tap 2 → no dout_valid pulse, mac_clr=1 while reset is low. The next sample 3 with coef {1,1,1,1} yields dout=3 because history was discarded.
